// File: rtl/comparador_pkg.sv
`default_nettype none
// ============================================================================
// Module   : comparador_pkg
// Brief    : Shared types and constants for the 4-bit constant comparator
//            and its sequencing controller.
// Revision : 1.0 - initial release
// ============================================================================
package comparador_pkg;

    // Controller states; explicit 2-bit encoding keeps the state register
    // width fixed regardless of tool enum defaults.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } ctrl_state_t;

    // Pattern the sliding window is compared against (bit 3 = oldest bit).
    localparam logic [3:0] c_default_pattern = 4'b0101;

    // Number of bits in the sliding window.
    localparam int c_win_w = 4;

endpackage : comparador_pkg
`default_nettype wire

// File: rtl/comparador_const.sv
`default_nettype none
// ============================================================================
// Module   : comparador_const
// Brief    : Compares four single-bit inputs against a constant pattern.
//            One XNOR per bit, then a 4-input AND.
// Revision : 1.0 - initial release
// ============================================================================
module comparador_const
    import comparador_pkg::*;
#(
    parameter logic [c_win_w-1:0] PATTERN = c_default_pattern
) (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic Q
);

    logic [c_win_w-1:0] w_in;
    logic [c_win_w-1:0] w_bit_eq;

    // a is the oldest bit and lines up with PATTERN[3].
    assign w_in     = {a, b, c, d};
    assign w_bit_eq = w_in ~^ PATTERN;
    assign Q        = &w_bit_eq;

endmodule : comparador_const
`default_nettype wire

// File: rtl/comparador_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : comparador_seq_ctrl
// Brief    : Accepts a framed serial bit stream over valid/ready, slides it
//            through a 4-bit window, and reports pattern-match pulses plus a
//            saturating per-frame match count.
// Revision : 1.0 - initial release
// ============================================================================
module comparador_seq_ctrl
    import comparador_pkg::*;
#(
    parameter logic [c_win_w-1:0] PATTERN   = c_default_pattern,
    parameter int                 FRAME_LEN = 16,
    parameter int                 CNT_W     = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    output logic             busy,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             done
);

    localparam logic [7:0]       c_frame_len = 8'(FRAME_LEN);
    localparam logic [7:0]       c_fill_bits = 8'(c_win_w - 1);
    localparam logic [CNT_W-1:0] c_cnt_max   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

    // The window's oldest bit is exactly the one shifted out on the next
    // acceptance, so only the three most recent bits need storage; the
    // incoming bit completes the 4-bit window.
    ctrl_state_t              r_state_q,       w_state_d;
    logic [c_win_w-2:0]       r_window_q,      w_window_d;
    logic [7:0]               r_bit_cnt_q,     w_bit_cnt_d;
    logic [CNT_W-1:0]         r_match_count_q, w_match_count_d;
    logic                     r_match_q,       w_match_d;
    logic                     r_done_q,        w_done_d;

    logic                     w_active;
    logic                     w_accept;
    logic [c_win_w-1:0]       w_window_next;
    logic [7:0]               w_bit_cnt_inc;
    logic                     w_last_bit;
    logic                     w_cmp_q;

    // Handshake and window helpers, decoded from registered state only.
    always_comb begin
        w_active      = (r_state_q == FILL) || (r_state_q == RUN);
        w_accept      = bit_valid && w_active;
        w_window_next = {r_window_q, bit_in};
        w_bit_cnt_inc = r_bit_cnt_q + 8'd1;
        w_last_bit    = (w_bit_cnt_inc == c_frame_len);
    end

    // Comparator sees the window that includes the bit being accepted.
    comparador_const #(
        .PATTERN (PATTERN)
    ) u_cmp (
        .a (w_window_next[3]),
        .b (w_window_next[2]),
        .c (w_window_next[1]),
        .d (w_window_next[0]),
        .Q (w_cmp_q)
    );

    // Next-state, window, counter and output-pulse computation.
    always_comb begin
        w_state_d       = r_state_q;
        w_window_d      = r_window_q;
        w_bit_cnt_d     = r_bit_cnt_q;
        w_match_count_d = r_match_count_q;
        w_match_d       = 1'b0;
        w_done_d        = 1'b0;
        case (r_state_q)
            IDLE: begin
                if (start) begin
                    w_state_d       = FILL;
                    w_window_d      = '0;
                    w_bit_cnt_d     = 8'd0;
                    w_match_count_d = '0;
                end
            end
            FILL: begin
                if (w_accept) begin
                    w_window_d  = w_window_next[c_win_w-2:0];
                    w_bit_cnt_d = w_bit_cnt_inc;
                    if (w_bit_cnt_inc == c_fill_bits) begin
                        w_state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (w_accept) begin
                    w_window_d  = w_window_next[c_win_w-2:0];
                    w_bit_cnt_d = w_bit_cnt_inc;
                    if (w_cmp_q) begin
                        w_match_d = 1'b1;
                        if (r_match_count_q != c_cnt_max) begin
                            w_match_count_d = r_match_count_q + c_cnt_one;
                        end
                    end
                    if (w_last_bit) begin
                        w_state_d = DONE;
                        w_done_d  = 1'b1;
                    end
                end
            end
            DONE: begin
                w_state_d = IDLE;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_q       <= IDLE;
            r_window_q      <= '0;
            r_bit_cnt_q     <= 8'd0;
            r_match_count_q <= '0;
            r_match_q       <= 1'b0;
            r_done_q        <= 1'b0;
        end else begin
            r_state_q       <= w_state_d;
            r_window_q      <= w_window_d;
            r_bit_cnt_q     <= w_bit_cnt_d;
            r_match_count_q <= w_match_count_d;
            r_match_q       <= w_match_d;
            r_done_q        <= w_done_d;
        end
    end

    assign bit_ready   = w_active;
    assign busy        = w_active;
    assign match       = r_match_q;
    assign match_count = r_match_count_q;
    assign done        = r_done_q;

endmodule : comparador_seq_ctrl
`default_nettype wire

// File: tb/tb_comparador_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_comparador_seq_ctrl
// Brief    : Self-checking bench for comparador_seq_ctrl. Two instances share
//            one stimulus stream: default counter width and a 2-bit counter
//            that exercises saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_comparador_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       bit_in;
    logic       bit_valid;

    logic       ready_a, busy_a, match_a, done_a;
    logic [4:0] cnt_a;
    logic       ready_b, busy_b, match_b, done_b;
    logic [1:0] cnt_b;

    always #5 clk = ~clk;

    comparador_seq_ctrl #(
        .PATTERN   (4'b0101),
        .FRAME_LEN (16),
        .CNT_W     (5)
    ) dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .bit_ready   (ready_a),
        .busy        (busy_a),
        .match       (match_a),
        .match_count (cnt_a),
        .done        (done_a)
    );

    comparador_seq_ctrl #(
        .PATTERN   (4'b0101),
        .FRAME_LEN (16),
        .CNT_W     (2)
    ) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .bit_ready   (ready_b),
        .busy        (busy_b),
        .match       (match_b),
        .match_count (cnt_b),
        .done        (done_b)
    );

    typedef struct packed {
        logic       match;
        logic       done;
        logic       busy;
        logic       ready;
        logic [4:0] cnt_a;
        logic [1:0] cnt_b;
    } exp_t;

    exp_t sb_q[$];

    // Reference model: phase 0 = idle, 1 = receiving, 2 = end-of-frame cycle.
    int         m_phase = 0;
    int         m_pos   = 0;
    int         m_raw   = 0;
    logic [3:0] m_hist  = 4'd0;

    int total   = 0;
    int bad     = 0;
    int cyc     = 0;
    int done_at = -1;

    localparam logic [15:0] T1 = 16'b0101_0101_0000_0000;
    localparam logic [15:0] T2 = 16'b0101_0101_0101_0101;
    localparam logic [15:0] T4 = 16'b0000_0000_0000_0101;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, predict outputs for the following cycle, then compare.
    task automatic step(input logic st, input logic b, input logic v, input logic rn);
        exp_t e;
        logic acc;
        start     = st;
        bit_in    = b;
        bit_valid = v;
        rst_n     = rn;
        e   = '0;
        acc = v && (m_phase == 1);
        if (!rn) begin
            m_phase = 0; m_pos = 0; m_raw = 0; m_hist = 4'd0;
        end else begin
            case (m_phase)
                0: if (st) begin
                    m_phase = 1; m_pos = 0; m_raw = 0; m_hist = 4'd0;
                end
                1: if (acc) begin
                    m_hist = {m_hist[2:0], b};
                    m_pos++;
                    if (m_pos >= 4 && m_hist == 4'b0101) begin
                        m_raw++;
                        e.match = 1'b1;
                    end
                    if (m_pos == 16) begin
                        m_phase = 2;
                        e.done  = 1'b1;
                    end
                end
                default: m_phase = 0;
            endcase
        end
        e.busy  = (m_phase == 1);
        e.ready = (m_phase == 1);
        e.cnt_a = (m_raw > 31) ? 5'd31 : 5'(m_raw);
        e.cnt_b = (m_raw > 3)  ? 2'd3  : 2'(m_raw);
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        cyc++;
        e = sb_q.pop_front();
        check("a_match", 8'(match_a), 8'(e.match));
        check("a_done",  8'(done_a),  8'(e.done));
        check("a_busy",  8'(busy_a),  8'(e.busy));
        check("a_ready", 8'(ready_a), 8'(e.ready));
        check("a_count", 8'(cnt_a),   8'(e.cnt_a));
        check("b_match", 8'(match_b), 8'(e.match));
        check("b_done",  8'(done_b),  8'(e.done));
        check("b_busy",  8'(busy_b),  8'(e.busy));
        check("b_count", 8'(cnt_b),   8'(e.cnt_b));
        if (done_a) done_at = cyc;
    endtask

    // mode 0: valid every cycle; 1: valid toggles; 2: start held high throughout.
    task automatic run_frame(input logic [15:0] data, input int mode,
                             input logic [4:0] exp_a, input logic [1:0] exp_b);
        cyc     = 0;
        done_at = -1;
        step(1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 64 && m_phase == 1; k++) begin
            logic v;
            v = (mode != 1) || (k % 2 == 0);
            step(mode == 2, v ? data[15 - m_pos] : 1'($urandom_range(0, 1)), v, 1'b1);
        end
        check("done_cycle", 8'(done_at), (mode == 1) ? 8'd32 : 8'd17);
        // DONE cycle: start and bit_valid must both be ignored.
        step(mode == 2, 1'b1, 1'b1, 1'b1);
        check("final_count_a", 8'(cnt_a), 8'(exp_a));
        check("final_count_b", 8'(cnt_b), 8'(exp_b));
        // Idle with valid asserted: nothing accepted, count held.
        step(1'b0, 1'b1, 1'b1, 1'b1);
        check("held_count_a", 8'(cnt_a), 8'(exp_a));
        check("idle_ready", 8'(ready_a), 8'd0);
    endtask

    initial begin
        start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; rst_n = 1'b0;

        // Reset state.
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("reset_count", 8'(cnt_a), 8'd0);

        // Idle ignores bit_valid.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b1);

        // Basic frame, matches after bits 4, 6, 8.
        run_frame(T1, 0, 5'd3, 2'd3);
        // Repeating 0101: seven matches, narrow counter saturates.
        run_frame(T2, 0, 5'd7, 2'd3);
        // Stalled stream gives identical result.
        run_frame(T1, 1, 5'd3, 2'd3);
        // Last-bit match coincides with done.
        run_frame(T4, 0, 5'd1, 2'd1);
        // start held high in FILL, RUN and DONE has no effect.
        run_frame(T1, 2, 5'd3, 2'd3);

        // Reset during the 9th bit aborts the frame without done.
        cyc     = 0;
        done_at = -1;
        step(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, T1[15 - i], 1'b1, 1'b1);
        step(1'b0, T1[7], 1'b1, 1'b0);
        check("abort_no_done", 8'(done_at), 8'hFF);
        check("abort_count", 8'(cnt_a), 8'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        run_frame(T1, 0, 5'd3, 2'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_comparador_seq_ctrl
`default_nettype wire

// File: doc/comparador_seq_ctrl.md
# comparador_seq_ctrl

Sequencing controller for the 4-bit constant comparator. It accepts a framed serial bit stream over a valid/ready handshake and shifts it into a 4-bit sliding window. Each full window is compared against a constant pattern, and the controller reports per-bit match pulses plus a saturating per-frame match count. It sits between a serial source and downstream logic that needs "pattern 0101 seen" events, in place of hand-wired comparator inputs.

## Interface
- PATTERN, 4'b0101, constant the window is compared against; bit 3 is the oldest bit in the window.
- FRAME_LEN, 16, bits per frame; legal range 4..255.
- CNT_W, 5, match counter width; the counter saturates at 2^CNT_W-1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  begin a frame; sampled only in IDLE.
- bit_in  in  1  serial data bit.
- bit_valid  in  1  bit_in is valid this cycle.
- bit_ready  out  1  controller accepts a bit this cycle.
- busy  out  1  frame in progress.
- match  out  1  one-cycle pulse: the window just completed equals PATTERN.
- match_count  out  CNT_W  matches in the current or last frame.
- done  out  1  one-cycle pulse at end of frame.

## Operation
- Bit acceptance: a bit is accepted when bit_valid && bit_ready.
- Window update: on acceptance, window <= {window[2:0], bit_in}. The newest bit is window[0] (comparator input d); the oldest is window[3] (input a).
- FSM states: IDLE, FILL, RUN, DONE.
  - IDLE: bit_ready=0, busy=0. When start=1: clear window, bit counter and match_count, then go to FILL.
  - FILL: bit_ready=1, busy=1. Accept 3 bits with no comparison. After the 3rd accepted bit, go to RUN.
  - RUN: bit_ready=1, busy=1. Every accepted bit completes a window, and the window including that bit is compared. When bit counter == FRAME_LEN after an acceptance, go to DONE.
  - DONE: bit_ready=0, busy=0, done=1 for exactly one cycle, then go to IDLE.
- Matching:
  - Overlapping matches count. For example, 0101_01 yields two matches.
  - On each match, match_count increments and saturates at all-ones.
- start is ignored outside IDLE. start asserted during the DONE cycle is also ignored.
- match_count holds its value after DONE until the next accepted start.
- Bit counter is 8 bits wide and counts accepted bits in the frame. It never wraps, because FRAME_LEN ≤ 255.
- Stalls: bit_valid=0 in FILL or RUN holds all state. There is no timeout.

## Timing
- Reset (rst_n=0 at a clk edge) puts the block in IDLE and clears window, bit counter and match_count. Output values after reset: bit_ready=0, busy=0, match=0, done=0, match_count=0.
- Reset mid-frame aborts the frame immediately: no done pulse and no match is emitted.
- start accepted at edge N: busy=1 and bit_ready=1 from cycle N+1.
- Match latency: a bit accepted at edge N that completes a matching window gives match=1 during cycle N+1. match_count shows the incremented value in the same cycle.
- Last bit of a frame accepted at edge N:
  - done=1 and busy=0 during cycle N+1.
  - A match on that last bit pulses in the same cycle as done.
  - IDLE from cycle N+2.
- Minimum frame duration: FRAME_LEN + 2 cycles, including the start cycle and DONE.
- All outputs are registered, except bit_ready and busy, which decode the state register with no combinational path from inputs.

## Structure
- Package comparador_pkg holds:
  - typedef enum logic [1:0] ctrl_state_t {IDLE, FILL, RUN, DONE}
  - localparam default pattern 4'b0101
  - localparam window width 4
- Sub-module comparador_const, parameterized by PATTERN: 4 inputs a, b, c, d plus output Q, built as an XNOR-per-bit / AND4 structure.
  - The controller instantiates one comparador_const on the window and registers its Q, qualified by acceptance in RUN, as match.

## Test plan
1. Reset, start, frame 0101_0101_0000_0000 with bit_valid=1 every cycle → match pulses after accepted bits 4, 6, 8; match_count=3; done at cycle 18 after start.
2. Frame of 16 bits of repeating 0101, CNT_W=2 → 7 raw matches; match_count saturates at 3 and stays 3 after done.
3. Same stream as scenario 1 with bit_valid toggled 1/0 each cycle → identical match sequence and match_count=3; state frozen during bit_valid=0; done after 32 cycles of stream.
4. Frame ending ...0101 (FRAME_LEN=16) → match and done asserted in the same cycle; count includes the last match.
5. rst_n=0 during the 9th bit of scenario 1 → next cycle IDLE with all outputs zero; no done pulse. A new start then gives a clean count.
6. start pulsed in FILL, RUN and DONE → no effect. Bits are accepted only between start and DONE; bit_ready=0 in IDLE ignores bit_valid.
